// File: rtl/im_fetch_ctrl.sv
// Instruction-memory sequencer: byte-stream program load, then PC-driven fetch until ebreak/fault.
// Load write lands 1 cycle after the completing byte (ld_ready drops that cycle); fetch is combinational, pc registered.
module im_fetch_ctrl #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic                  start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  im_we,
    output logic [ADDR_BITS-1:0]  im_waddr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic [ADDR_BITS-1:0]  im_raddr,
    input  logic [DATA_WIDTH-1:0] im_rdata,
    input  logic                  stall,
    input  logic                  pc_src,
    input  logic [31:0]           pc_target,
    output logic [31:0]           pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [1:0]            state,
    output logic                  err,
    output logic [ADDR_BITS:0]    words_loaded
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3} state_t;

    localparam logic [DATA_WIDTH-1:0] EBREAK    = 32'h0010_0073;
    localparam logic [DATA_WIDTH-1:0] NOP       = 32'h0000_0013;
    localparam logic [ADDR_BITS:0]    DEPTH     = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]    WORDS_ONE = 1;
    localparam logic [ADDR_BITS-1:0]  PTR_ONE   = 1;

    state_t                r_state;
    logic [31:0]           r_pc;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [ADDR_BITS-1:0]  r_wptr;
    logic [ADDR_BITS:0]    r_words;
    logic                  r_err;
    logic                  r_we;
    logic                  r_last;

    logic                  w_accept;
    logic [31:0]           w_pc_next;

    assign w_accept  = ld_valid && ld_ready;
    assign w_pc_next = pc_src ? pc_target : r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_wptr  <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (load_req) begin
                        r_state <= S_LOAD;
                        r_words <= '0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_wptr  <= '0;
                        r_buf   <= '0;
                    end else if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_we) begin
                        r_we    <= 1'b0;
                        r_wptr  <= r_wptr + PTR_ONE;
                        r_words <= r_words + WORDS_ONE;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                        if (r_last) r_state <= S_IDLE;
                    end else if (w_accept) begin
                        // A full memory turns any further byte into a fault instead of a wrapping write.
                        if (r_words == DEPTH) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_buf[{r_cnt, 3'b000} +: 8] <= ld_data;
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3 || ld_last) begin
                                r_we   <= 1'b1;
                                r_last <= ld_last;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (im_rdata == EBREAK) begin
                            r_state <= S_HALT;
                        end else if (pc_src && pc_target[1:0] != 2'b00) begin
                            r_state <= S_HALT;
                            r_err   <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_ready     = (r_state == S_LOAD) && !r_we;
    assign im_we        = r_we;
    assign im_waddr     = r_wptr;
    assign im_wdata     = r_buf;
    assign im_raddr     = r_pc[ADDR_BITS+1:2];
    assign pc           = r_pc;
    assign instr_valid  = (r_state == S_RUN);
    assign instr        = instr_valid ? im_rdata : NOP;
    assign state        = r_state;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl with a behavioural instruction memory attached.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, load_req, start, ld_valid, ld_last, stall, pc_src;
    logic [7:0]  ld_data;
    logic [31:0] pc_target, im_rdata, im_wdata, pc, instr;
    logic        ld_ready, im_we, instr_valid, err;
    logic [4:0]  im_waddr, im_raddr;
    logic [1:0]  state;
    logic [5:0]  words_loaded;

    logic [31:0] mem [0:31];
    logic [4:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_n = 0;
    int          rdy_viol = 0;
    int          checks = 0;
    int          errors = 0;

    im_fetch_ctrl #(.ADDR_BITS(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata), .im_raddr(im_raddr),
        .im_rdata(im_rdata), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .pc(pc), .instr(instr), .instr_valid(instr_valid), .state(state), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    assign im_rdata = mem[im_raddr];

    always @(posedge clk) begin
        if (im_we) begin
            mem[im_waddr] <= im_wdata;
            if (wr_n < 64) begin
                wr_addr[wr_n] = im_waddr;
                wr_data[wr_n] = im_wdata;
            end
            wr_n = wr_n + 1;
            if (ld_ready) rdy_viol = rdy_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ld_ready) begin
            checks++;
            errors++;
            $display("FAIL ld_ready_timeout: ld_ready=%0b after %0d cycles, required 1", ld_ready, n);
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], last && (b == 3));
    endtask

    task automatic begin_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL enter_load: state=%0d required 1", state); end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (state !== 2'd0 || pc !== 32'd0 || words_loaded !== 6'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: state=%0d pc=%h words=%0d err=%0b required 0/0/0/0", state, pc, words_loaded, err);
        end
        checks++;
        if (ld_ready !== 1'b0 || im_we !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: ld_ready=%0b im_we=%0b instr_valid=%0b required 0/0/0", ld_ready, im_we, instr_valid);
        end
        checks++;
        if (instr !== 32'h00000013) begin errors++; $display("FAIL reset_instr: instr=%h required 00000013", instr); end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_basic();
        int base;
        base = wr_n;
        begin_load();
        send_word(32'h00300413, 1'b0);
        send_word(32'h00100493, 1'b1);
        tick();
        checks++;
        if (wr_n - base !== 2) begin errors++; $display("FAIL basic_write_count: got %0d required 2", wr_n - base); end
        checks++;
        if (wr_addr[base] !== 5'd0 || wr_data[base] !== 32'h00300413) begin
            errors++;
            $display("FAIL basic_word0: addr=%0d data=%h required 0/00300413", wr_addr[base], wr_data[base]);
        end
        checks++;
        if (wr_addr[base+1] !== 5'd1 || wr_data[base+1] !== 32'h00100493) begin
            errors++;
            $display("FAIL basic_word1: addr=%0d data=%h required 1/00100493", wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if (words_loaded !== 6'd2 || state !== 2'd0) begin
            errors++;
            $display("FAIL basic_done: words=%0d state=%0d required 2/0", words_loaded, state);
        end
        checks++;
        if (rdy_viol !== 0) begin errors++; $display("FAIL ready_during_write: %0d violations, required 0", rdy_viol); end
    endtask

    task automatic test_partial_word();
        int base;
        logic [7:0] bytes [0:4];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        base = wr_n;
        begin_load();
        for (int i = 0; i < 5; i++) send_byte(bytes[i], i == 4);
        tick();
        checks++;
        if (wr_data[base] !== 32'h04030201) begin errors++; $display("FAIL partial_word0: got %h required 04030201", wr_data[base]); end
        checks++;
        if (wr_addr[base+1] !== 5'd1 || wr_data[base+1] !== 32'h000000AA) begin
            errors++;
            $display("FAIL partial_word1: addr=%0d data=%h required 1/000000aa", wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if (words_loaded !== 6'd2 || state !== 2'd0) begin
            errors++;
            $display("FAIL partial_done: words=%0d state=%0d required 2/0", words_loaded, state);
        end
    endtask

    task automatic test_overflow();
        int base;
        logic [7:0] b;
        base = wr_n;
        begin_load();
        for (int i = 0; i < 129; i++) begin
            b = 8'((i * 7 + 1) & 255);
            send_byte(b, 1'b0);
        end
        tick();
        checks++;
        if (wr_n - base !== 32) begin errors++; $display("FAIL overflow_writes: got %0d required 32", wr_n - base); end
        checks++;
        if (err !== 1'b1 || state !== 2'd0 || words_loaded !== 6'd32) begin
            errors++;
            $display("FAIL overflow_flags: err=%0b state=%0d words=%0d required 1/0/32", err, state, words_loaded);
        end
        checks++;
        if (wr_addr[base+31] !== 5'd31 || wr_data[base+31] !== 32'h7A736C65) begin
            errors++;
            $display("FAIL overflow_last_word: addr=%0d data=%h required 31/7a736c65", wr_addr[base+31], wr_data[base+31]);
        end
    endtask

    task automatic test_run_program();
        begin_load();
        send_word(32'h00300413, 1'b0);
        send_word(32'h00100493, 1'b0);
        send_word(32'h00100073, 1'b1);
        tick();
        checks++;
        if (err !== 1'b0 || words_loaded !== 6'd3) begin
            errors++;
            $display("FAIL prog_load: err=%0b words=%0d required 0/3", err, words_loaded);
        end
        pulse_start();
        checks++;
        if (state !== 2'd2 || pc !== 32'd0 || instr_valid !== 1'b1 || instr !== 32'h00300413) begin
            errors++;
            $display("FAIL run_start: state=%0d pc=%h valid=%0b instr=%h required 2/0/1/00300413", state, pc, instr_valid, instr);
        end
        tick();
        checks++;
        if (pc !== 32'd4) begin errors++; $display("FAIL run_pc4: pc=%h required 4", pc); end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        checks++;
        if (pc !== 32'd4 || instr !== 32'h00100493) begin
            errors++;
            $display("FAIL stall_hold: pc=%h instr=%h required 4/00100493", pc, instr);
        end
        tick();
        checks++;
        if (pc !== 32'd8 || instr !== 32'h00100073 || state !== 2'd2) begin
            errors++;
            $display("FAIL run_pc8: pc=%h instr=%h state=%0d required 8/00100073/2", pc, instr, state);
        end
        tick();
        checks++;
        if (state !== 2'd3 || pc !== 32'd8 || instr !== 32'h00000013 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_halt: state=%0d pc=%h instr=%h valid=%0b required 3/8/00000013/0", state, pc, instr, instr_valid);
        end
    endtask

    task automatic test_branch();
        pulse_start();
        pc_src = 1'b1;
        pc_target = 32'h10;
        tick();
        checks++;
        if (pc !== 32'h10 || state !== 2'd2) begin errors++; $display("FAIL branch_taken: pc=%h state=%0d required 10/2", pc, state); end
        pc_target = 32'h12;
        tick();
        checks++;
        if (state !== 2'd3 || err !== 1'b1 || pc !== 32'h10) begin
            errors++;
            $display("FAIL misaligned_fault: state=%0d err=%0b pc=%h required 3/1/10", state, err, pc);
        end
        pulse_start();
        pc_target = 32'h7C;
        tick();
        pc_src = 1'b0;
        checks++;
        if (pc !== 32'h7C || im_raddr !== 5'd31) begin errors++; $display("FAIL jump_7c: pc=%h raddr=%0d required 7c/31", pc, im_raddr); end
        tick();
        checks++;
        if (pc !== 32'h80 || im_raddr !== 5'd0 || state !== 2'd2) begin
            errors++;
            $display("FAIL raddr_wrap: pc=%h raddr=%0d state=%0d required 80/0/2", pc, im_raddr, state);
        end
    endtask

    task automatic test_reset_abort();
        int base;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || pc !== 32'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: state=%0d pc=%h valid=%0b required 0/0/0", state, pc, instr_valid);
        end
        rst_n = 1'b1;
        tick();
        begin_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || im_we !== 1'b0 || ld_ready !== 1'b0 || words_loaded !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_word: state=%0d im_we=%0b ld_ready=%0b words=%0d required 0/0/0/0", state, im_we, ld_ready, words_loaded);
        end
        rst_n = 1'b1;
        tick();
        base = wr_n;
        begin_load();
        send_word(32'hDEADBEEF, 1'b1);
        tick();
        checks++;
        if (wr_n - base !== 1 || wr_addr[base] !== 5'd0 || wr_data[base] !== 32'hDEADBEEF || words_loaded !== 6'd1) begin
            errors++;
            $display("FAIL reload_after_reset: writes=%0d addr=%0d data=%h words=%0d required 1/0/deadbeef/1", wr_n - base, wr_addr[base], wr_data[base], words_loaded);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_req = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_data = 8'h00; stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        test_reset();
        test_load_basic();
        test_partial_word();
        test_overflow();
        test_run_program();
        test_branch();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
# im_fetch_ctrl

Sequencing controller for the 32-word instruction memory (IM) of the single-cycle RISC-V core. It loads a program into the IM over an 8-bit valid/ready byte stream, then runs fetch by owning the program counter. In the run state it presents the IM read address and the fetched instruction to the datapath, and applies branch/jump targets. It stops on `ebreak` or on a fault. The IM gains a synchronous write port driven by this block, and its read stays combinational.

## Interface
- `ADDR_BITS`, 5, IM word-address width; depth = 2**ADDR_BITS words
- `DATA_WIDTH`, 32, instruction width (fixed at 32)
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `load_req`  in  1  start a program load (IDLE/HALT only)
- `start`  in  1  start execution from pc=0 (IDLE/HALT only)
- `ld_valid`  in  1  load byte valid
- `ld_data`  in  8  load byte
- `ld_last`  in  1  qualifies the final byte of the program
- `ld_ready`  out  1  byte accepted when `ld_valid && ld_ready`
- `im_we`  out  1  IM write enable, one-cycle pulse
- `im_waddr`  out  ADDR_BITS  IM write word address
- `im_wdata`  out  32  IM write data
- `im_raddr`  out  ADDR_BITS  IM read address = `pc[ADDR_BITS+1:2]`
- `im_rdata`  in  32  IM combinational read data
- `stall`  in  1  datapath hold; pc frozen
- `pc_src`  in  1  1 = take `pc_target`
- `pc_target`  in  32  branch/jump target
- `pc`  out  32  current program counter
- `instr`  out  32  instruction to the datapath
- `instr_valid`  out  1  `instr` is a real fetched instruction
- `state`  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
- `err`  out  1  sticky fault flag
- `words_loaded`  out  ADDR_BITS+1  number of words written by the last load

## Operation
- Reset values: state=IDLE, pc=0, byte count=0, word buffer=0, `words_loaded`=0, `err`=0. All strobes are 0, including `ld_ready`, `im_we` and `instr_valid`.
- IDLE/HALT transitions:
  - `load_req` moves to LOAD. It clears `words_loaded`, `err`, the byte count and the write pointer.
  - Else `start` moves to RUN with pc<=0.
  - `load_req` has priority over `start`.
  - Both inputs are ignored in LOAD and RUN.
- LOAD, `ld_ready`=1:
  - Accepted bytes assemble little-endian: byte k goes to bits [8k+7:8k].
  - On the 4th byte, or on any byte with `ld_last`=1, the next cycle drives `im_we`=1 with `im_waddr` = write pointer and `im_wdata` = assembled word.
  - Unfilled bytes of a partial word are zero.
  - `ld_ready`=0 during the write cycle.
  - After the write, the pointer and `words_loaded` increment and the buffer clears.
  - The write of an `ld_last` word returns to IDLE.
- Overflow: a byte accepted when `words_loaded` = 2**ADDR_BITS sets `err`=1. The byte is dropped, no write occurs, and the state goes to IDLE.
- RUN:
  - `instr` = `im_rdata`, `instr_valid`=1.
  - When `stall`=0, pc <= `pc_target` if `pc_src` else pc+4.
  - pc is 32-bit; `im_raddr` wraps modulo depth, which is the intended wrap-around.
- RUN to HALT (only when `stall`=0), pc held:
  - `instr` = 0x00100073 (`ebreak`): HALT, `err` unchanged.
  - `pc_src`=1 with `pc_target[1:0]`≠0: HALT, `err`=1.
- Outside RUN: `instr` = 0x00000013 (NOP), `instr_valid`=0.
- Reset asserted mid-load or mid-run aborts immediately to the reset values. IM contents are not cleared.

## Timing
- `rst_n` low clears all state asynchronously. Release is sampled at the next rising `clk`.
- Byte accept to `im_we`: 1 cycle. Sustained load rate is 4 bytes per 5 cycles.
- Fetch: zero-latency combinational path `pc` → `im_raddr` → `im_rdata` → `instr`. The pc update is registered at the edge.
- `start` sampled at edge N: pc=0 and `instr_valid`=1 during cycle N+1.
- `ebreak` present at edge N with `stall`=0: `state`=HALT and `instr_valid`=0 in cycle N+1, pc = address of the `ebreak`.
- `stall`=1 in RUN: pc, `instr` and state hold. `ebreak` or a fault is not acted on until `stall`=0.

## Test plan
- Load bytes 13,04,30,00,93,04,10,00 with `ld_last` on the final byte. Required response: writes 0x00300413 at addr 0 and 0x00100493 at addr 1, `words_loaded`=2, state returns to IDLE, `ld_ready`=0 on both write cycles.
- Load 5 bytes 01,02,03,04,AA with `ld_last` on the final byte. Required response: word1 written as 0x000000AA, `words_loaded`=2.
- Load 33 full words. Required response: first 32 are written, the 129th byte sets `err`=1, state=IDLE, no 33rd write.
- Program {addi, addi, ebreak} then `start`. Required response: pc sequence 0,4,8, then HALT with pc=8 and `instr` = NOP. A `stall` pulse at pc=4 holds pc for exactly 1 cycle.
- RUN with `pc_src`=1 and target 0x10. Required response: next pc = 0x10. With target 0x12: HALT, `err`=1. With pc=0x7C and no branch: `im_raddr` wraps to 0.
- `rst_n` low mid-word and mid-run. Required response: immediately state=IDLE, pc=0, `im_we`=0. A following load starts at addr 0.
